// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS-subset controller: states, opcodes,
// ALU/mux select codes and the control-word payload.
package mc_ctrl_pkg;

    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned ST_W     = 4;
    localparam int unsigned SEL_W    = 2;

    typedef enum logic [ST_W-1:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        IMMWB  = 4'd11,
        ORIEX  = 4'd12,
        TRAP   = 4'd13
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OPCODE_W-1:0] OP_ORI   = 6'b001101;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [SEL_W-1:0] ALUOP_OR    = 2'b11;

    localparam logic [SEL_W-1:0] SRCB_B       = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic             pcwrite;
        logic             pcwritecond;
        logic             iord;
        logic             memread;
        logic             memwrite;
        logic             irwrite;
        logic             regdst;
        logic             memtoreg;
        logic             regwrite;
        logic             alusrca;
        logic [SEL_W-1:0] alusrcb;
        logic [SEL_W-1:0] aluop;
        logic [SEL_W-1:0] pcsource;
    } ctrl_word_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Pure state-to-control-word decoder; FETCH write enables wait for memory ready.
module mc_ctrl_outdec
    import mc_ctrl_pkg::*;
(
    input  state_t     state,
    input  logic       mem_rdy,
    output ctrl_word_t cw
);

    always_comb begin
        cw = '0;
        case (state)
            FETCH: begin
                cw.memread  = 1'b1;
                cw.irwrite  = mem_rdy;
                cw.pcwrite  = mem_rdy;
                cw.alusrcb  = SRCB_FOUR;
                cw.aluop    = ALUOP_ADD;
                cw.pcsource = PCSRC_ALU;
            end
            DECODE: begin
                cw.alusrcb = SRCB_IMM_SH2;
                cw.aluop   = ALUOP_ADD;
            end
            MEMADR, ADDIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_ADD;
            end
            MEMRD: begin
                cw.memread = 1'b1;
                cw.iord    = 1'b1;
            end
            MEMWB: begin
                cw.memtoreg = 1'b1;
                cw.regwrite = 1'b1;
            end
            MEMWR: begin
                cw.memwrite = 1'b1;
                cw.iord     = 1'b1;
            end
            EXEC: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_B;
                cw.aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                cw.regdst   = 1'b1;
                cw.regwrite = 1'b1;
            end
            BRANCH: begin
                cw.alusrca     = 1'b1;
                cw.alusrcb     = SRCB_B;
                cw.aluop       = ALUOP_SUB;
                cw.pcsource    = PCSRC_ALUOUT;
                cw.pcwritecond = 1'b1;
            end
            JUMP: begin
                cw.pcsource = PCSRC_JUMP;
                cw.pcwrite  = 1'b1;
            end
            ORIEX: begin
                cw.alusrca = 1'b1;
                cw.alusrcb = SRCB_IMM;
                cw.aluop   = ALUOP_OR;
            end
            IMMWB: begin
                cw.regwrite = 1'b1;
            end
            default: cw = '0;
        endcase
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main control FSM for the MIPS-subset datapath.
// Define ILLEGAL_OP_TRAP_EN to trap unknown opcodes in TRAP and expose IllegalOp.
module mc_main_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned STATE_W       = 4,
    parameter bit          USE_MEM_READY = 1'b1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [OPCODE_W-1:0] Opcode,
    input  logic                Zero,
    input  logic                MemReady,
    output logic                PCEn,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                RegDst,
    output logic                MemtoReg,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [SEL_W-1:0]    ALUSrcB,
    output logic [SEL_W-1:0]    ALUOp,
    output logic [SEL_W-1:0]    PCSource,
    output logic [STATE_W-1:0]  State
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic                IllegalOp
`endif
);

    state_t     state_q;
    state_t     state_d;
    logic       mem_rdy;
    ctrl_word_t cw;
    ctrl_word_t cw_g;

    assign mem_rdy = USE_MEM_READY ? MemReady : 1'b1;

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; Opcode is only consulted in DECODE and MEMADR
    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:  state_d = mem_rdy ? DECODE : FETCH;
            DECODE: begin
                case (Opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXEC;
                    OP_BEQ:       state_d = BRANCH;
                    OP_J:         state_d = JUMP;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_ORI:       state_d = ORIEX;
`ifdef ILLEGAL_OP_TRAP_EN
                    default:      state_d = TRAP;
`else
                    default:      state_d = FETCH;
`endif
                endcase
            end
            MEMADR: state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:  state_d = mem_rdy ? MEMWB : MEMRD;
            MEMWB:  state_d = FETCH;
            MEMWR:  state_d = mem_rdy ? FETCH : MEMWR;
            EXEC:   state_d = ALUWB;
            ALUWB:  state_d = FETCH;
            BRANCH: state_d = FETCH;
            JUMP:   state_d = FETCH;
            ADDIEX: state_d = IMMWB;
            ORIEX:  state_d = IMMWB;
            IMMWB:  state_d = FETCH;
`ifdef ILLEGAL_OP_TRAP_EN
            TRAP:   state_d = TRAP;
`endif
            default: state_d = FETCH;
        endcase
    end

    mc_ctrl_outdec u_outdec (
        .state   (state_q),
        .mem_rdy (mem_rdy),
        .cw      (cw)
    );

    // Reset blanks every output so no partial write lands in the reset cycle
    assign cw_g = Reset ? '0 : cw;

    assign PCEn     = cw_g.pcwrite | (cw_g.pcwritecond & Zero);
    assign IorD     = cw_g.iord;
    assign MemRead  = cw_g.memread;
    assign MemWrite = cw_g.memwrite;
    assign IRWrite  = cw_g.irwrite;
    assign RegDst   = cw_g.regdst;
    assign MemtoReg = cw_g.memtoreg;
    assign RegWrite = cw_g.regwrite;
    assign ALUSrcA  = cw_g.alusrca;
    assign ALUSrcB  = cw_g.alusrcb;
    assign ALUOp    = cw_g.aluop;
    assign PCSource = cw_g.pcsource;
    assign State    = Reset ? '0 : STATE_W'(state_q);

`ifdef ILLEGAL_OP_TRAP_EN
    assign IllegalOp = ~Reset & (state_q == TRAP);
`endif

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: per-instruction cycle plans checked
// against a table of expected control outputs per state.
module tb_mc_main_ctrl;

    localparam int unsigned STATE_W = 4;

    logic               Clk = 1'b0;
    logic               Reset = 1'b1;
    logic [5:0]         Opcode = '0;
    logic               Zero = 1'b0;
    logic               MemReady = 1'b1;
    logic               PCEn, IorD, MemRead, MemWrite, IRWrite;
    logic               RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0]         ALUSrcB, ALUOp, PCSource;
    logic [STATE_W-1:0] State;
`ifdef ILLEGAL_OP_TRAP_EN
    logic               IllegalOp;
`endif

    mc_main_ctrl #(.STATE_W(STATE_W), .USE_MEM_READY(1'b1)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Opcode   (Opcode),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCEn     (PCEn),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .IRWrite  (IRWrite),
        .RegDst   (RegDst),
        .MemtoReg (MemtoReg),
        .RegWrite (RegWrite),
        .ALUSrcA  (ALUSrcA),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .PCSource (PCSource),
        .State    (State)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .IllegalOp(IllegalOp)
`endif
    );

    always #5 Clk = ~Clk;

    // One planned cycle: expected state, MemReady to drive, Reset to drive
    typedef struct {
        int st;
        bit mr;
        bit rst;
    } step_t;

    step_t       plan[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          zero_mode = -1;
    logic [18:0] act;

    assign act = {State, PCEn, IorD, MemRead, MemWrite, IRWrite, RegDst,
                  MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};

    function automatic step_t mk(int st, bit mr, bit rst);
        step_t s;
        s.st  = st;
        s.mr  = mr;
        s.rst = rst;
        return s;
    endfunction

    // Expected outputs for a state, straight from the controller's output table
    function automatic logic [18:0] model_outs(int st, bit mr, bit z, bit rst);
        logic [3:0] s;
        bit pcw, pcc, iord, mrd, mwr, irw, rd, m2r, rw, sa;
        logic [1:0] sb, op, ps;
        s = '0; pcw = 0; pcc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0;
        rd = 0; m2r = 0; rw = 0; sa = 0; sb = '0; op = '0; ps = '0;
        if (!rst) begin
            s = 4'(st);
            case (st)
                0:  begin mrd = 1; irw = mr; pcw = mr; sb = 2'b01; end
                1:  sb = 2'b11;
                2:  begin sa = 1; sb = 2'b10; end
                3:  begin mrd = 1; iord = 1; end
                4:  begin m2r = 1; rw = 1; end
                5:  begin mwr = 1; iord = 1; end
                6:  begin sa = 1; op = 2'b10; end
                7:  begin rd = 1; rw = 1; end
                8:  begin sa = 1; op = 2'b01; ps = 2'b01; pcc = 1; end
                9:  begin ps = 2'b10; pcw = 1; end
                10: begin sa = 1; sb = 2'b10; end
                11: rw = 1;
                12: begin sa = 1; sb = 2'b10; op = 2'b11; end
                default: ;
            endcase
        end
        return {s, pcw | (pcc & z), iord, mrd, mwr, irw, rd, m2r, rw, sa, sb, op, ps};
    endfunction

    // Instruction-level sequencing: fetch (with fw stalls), decode, then class body
    task automatic build_plan(input logic [5:0] op, input int fw, input int mw);
        repeat (fw) plan.push_back(mk(0, 1'b0, 1'b0));
        plan.push_back(mk(0, 1'b1, 1'b0));
        plan.push_back(mk(1, 1'($urandom), 1'b0));
        case (op)
            6'b100011: begin
                plan.push_back(mk(2, 1'($urandom), 1'b0));
                repeat (mw) plan.push_back(mk(3, 1'b0, 1'b0));
                plan.push_back(mk(3, 1'b1, 1'b0));
                plan.push_back(mk(4, 1'($urandom), 1'b0));
            end
            6'b101011: begin
                plan.push_back(mk(2, 1'($urandom), 1'b0));
                repeat (mw) plan.push_back(mk(5, 1'b0, 1'b0));
                plan.push_back(mk(5, 1'b1, 1'b0));
            end
            6'b000000: begin
                plan.push_back(mk(6, 1'($urandom), 1'b0));
                plan.push_back(mk(7, 1'($urandom), 1'b0));
            end
            6'b000100: plan.push_back(mk(8, 1'($urandom), 1'b0));
            6'b000010: plan.push_back(mk(9, 1'($urandom), 1'b0));
            6'b001000: begin
                plan.push_back(mk(10, 1'($urandom), 1'b0));
                plan.push_back(mk(11, 1'($urandom), 1'b0));
            end
            6'b001101: begin
                plan.push_back(mk(12, 1'($urandom), 1'b0));
                plan.push_back(mk(11, 1'($urandom), 1'b0));
            end
            default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                repeat (3) plan.push_back(mk(13, 1'($urandom), 1'b0));
                plan.push_back(mk(0, 1'($urandom), 1'b1));
`endif
            end
        endcase
    endtask

    task automatic run_plan(input string name, input logic [5:0] op);
        step_t       s;
        logic [18:0] exp;
        int          cyc;
        cyc = 0;
        while (plan.size() != 0) begin
            s = plan.pop_front();
            @(negedge Clk);
            Reset    = s.rst;
            MemReady = s.mr;
            Opcode   = op;
            Zero     = (zero_mode < 0) ? 1'($urandom) : 1'(zero_mode);
            #1;
            exp = model_outs(s.st, s.mr, Zero, s.rst);
            n_cmp++;
            if (act !== exp) begin
                n_bad++;
                $display("FAIL %s cycle %0d: outputs {State,PCEn..PCSource} got %b required %b",
                         name, cyc, act, exp);
            end
`ifdef ILLEGAL_OP_TRAP_EN
            n_cmp++;
            if (IllegalOp !== (!s.rst && s.st == 13)) begin
                n_bad++;
                $display("FAIL %s cycle %0d: IllegalOp got %b required %b",
                         name, cyc, IllegalOp, (!s.rst && s.st == 13));
            end
`endif
            cyc++;
        end
    endtask

    task automatic test_reset();
        zero_mode = -1;
        plan.push_back(mk(0, 1'($urandom), 1'b1));
        plan.push_back(mk(0, 1'($urandom), 1'b1));
        run_plan("reset", 6'($urandom));
    endtask

    task automatic test_rtype();
        build_plan(6'b000000, 0, 0);
        run_plan("rtype", 6'b000000);
    endtask

    task automatic test_lw_wait();
        build_plan(6'b100011, 0, 2);
        run_plan("lw_wait", 6'b100011);
    endtask

    task automatic test_beq();
        zero_mode = 1;
        build_plan(6'b000100, 0, 0);
        run_plan("beq_taken", 6'b000100);
        zero_mode = 0;
        build_plan(6'b000100, 0, 0);
        run_plan("beq_not_taken", 6'b000100);
        zero_mode = -1;
    endtask

    task automatic test_ori_sw();
        build_plan(6'b001101, 0, 0);
        run_plan("ori", 6'b001101);
        build_plan(6'b101011, 1, 0);
        run_plan("sw", 6'b101011);
    endtask

    task automatic test_illegal();
        build_plan(6'b111111, 0, 0);
        run_plan("illegal_op", 6'b111111);
    endtask

    task automatic test_reset_mid();
        plan.push_back(mk(0, 1'b1, 1'b0));
        plan.push_back(mk(1, 1'($urandom), 1'b0));
        plan.push_back(mk(2, 1'($urandom), 1'b0));
        plan.push_back(mk(5, 1'b0, 1'b0));
        plan.push_back(mk(5, 1'b0, 1'b0));
        plan.push_back(mk(0, 1'b0, 1'b1));
        run_plan("reset_in_memwr", 6'b101011);
        build_plan(6'b000010, 0, 0);
        run_plan("jump_after_reset", 6'b000010);
    endtask

    function automatic logic [5:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 6'b100011;
            1: return 6'b101011;
            2: return 6'b000000;
            3: return 6'b000100;
            4: return 6'b000010;
            5: return 6'b001000;
            6: return 6'b001101;
            default: return 6'($urandom);
        endcase
    endfunction

    task automatic test_back_to_back();
        logic [5:0] op;
        for (int i = 0; i < 60; i++) begin
            op = pick_op();
            build_plan(op, $urandom_range(0, 2), $urandom_range(0, 2));
            run_plan("random_stream", op);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_beq();
        test_ori_sw();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mc_main_ctrl.md
Name: mc_main_ctrl

Overview:
Multicycle main control FSM for the MIPS-subset datapath. Decodes Opcode, steps the shared ALU/memory/register-file datapath through fetch, decode, execute, memory and writeback, and drives ALUOp into ALU_CTRL. Waits on a memory-ready handshake. Sits between the instruction register and all datapath mux selects and write enables.

Parameters:
STATE_W, 4, state register width; must be >= 4.
USE_MEM_READY, 1, 1 = honour MemReady; 0 = treat MemReady as constant 1.

Ports:
Clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26]
Zero  in  1  ALU zero flag, for beq
MemReady  in  1  memory access complete this cycle
PCEn  out  1  PC load enable = PCWrite | (PCWriteCond & Zero)
IorD  out  1  0 = PC address, 1 = ALUOut address
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  load IR
RegDst  out  1  0 = rt, 1 = rd
MemtoReg  out  1  0 = ALUOut, 1 = MDR
RegWrite  out  1  register file write
ALUSrcA  out  1  0 = PC, 1 = A
ALUSrcB  out  2  00 B, 01 const 4, 10 signext imm, 11 signext imm<<2
ALUOp  out  2  to ALU_CTRL: 00 add, 01 sub, 10 funct, 11 or
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
State  out  STATE_W  current state (debug)

Behaviour:
- Reset: State <= FETCH (0) on a clock edge with Reset=1. While Reset=1, PCEn, MemRead, MemWrite, IRWrite and RegWrite are forced to 0. All other outputs are 0 during Reset.
- Outputs: Moore decode of State. Exception: PCEn also depends combinationally on Zero. Unlisted outputs are 0 in each state.
- States and outputs:
  - FETCH(0): MemRead, IRWrite, ALUSrcB=01, ALUOp=00, PCSource=00, PCWrite. IRWrite and PCWrite are asserted only when MemReady=1. Stay in FETCH while MemReady=0; go to DECODE on MemReady=1.
  - DECODE(1): ALUSrcB=11, ALUOp=00. Next state by Opcode:
    - 100011 (lw) or 101011 (sw) -> MEMADR
    - 000000 (R-type) -> EXEC
    - 000100 (beq) -> BRANCH
    - 000010 (j) -> JUMP
    - 001000 (addi) -> ADDIEX
    - 001101 (ori) -> ORIEX
    - any other opcode -> see Optional Feature
  - MEMADR(2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): MemRead, IorD. Stay while MemReady=0; then -> MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite. -> FETCH.
  - MEMWR(5): MemWrite, IorD. Stay while MemReady=0; then -> FETCH. MemWrite is held high for the whole wait.
  - EXEC(6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
  - ALUWB(7): RegDst=1, MemtoReg=0, RegWrite. -> FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWriteCond. -> FETCH.
  - JUMP(9): PCSource=10, PCWrite. -> FETCH.
  - ADDIEX(10): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> IMMWB.
  - ORIEX(12): ALUSrcA=1, ALUSrcB=10, ALUOp=11. -> IMMWB.
  - IMMWB(11): RegDst=0, MemtoReg=0, RegWrite. -> FETCH.
  - Unused encodings -> FETCH next cycle, all outputs 0.
- Latency with MemReady tied 1:
  - lw 5 cycles; sw, R-type, addi, ori 4; beq, j 3.
  - Each MemReady=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- Reset mid-instruction: the next state is FETCH unconditionally. No partial write is committed in the reset cycle.
- Opcode is sampled only in DECODE and MEMADR. It must be stable from the IR after FETCH.

Optional Feature:
Macro ILLEGAL_OP_TRAP_EN.
- Defined:
  - An unknown opcode in DECODE -> TRAP(13).
  - TRAP: all enables 0. Stays in TRAP until Reset.
  - Extra output IllegalOp (1 bit) is 1 in TRAP, 0 otherwise.
- Undefined: an unknown opcode in DECODE -> FETCH, executed as a 2-cycle NOP. No IllegalOp port.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state encoding constants (FETCH..TRAP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI)
  - ALUOp constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT, ALUOP_OR)
  - ALUSrcB and PCSource select constants
- The package is also used by the datapath top and ALU_CTRL binding.
- Optional sub-module mc_ctrl_outdec: pure state-to-control-word decoder. The state register and next-state logic stay in mc_main_ctrl.

Test Plan:
- Reset for 2 cycles, then release, MemReady=1:
  - State=0 during Reset with all enables 0.
  - First post-reset cycle: MemRead=1, IRWrite=1, PCEn=1, ALUSrcB=01.
- R-type (000000), MemReady=1: state sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 with RegDst=1 only in state 7.
- lw (100011) with MemReady low for 2 cycles in MEMRD: sequence 0,1,2,3,3,3,4,0. MemRead+IorD held through all state-3 cycles. RegWrite+MemtoReg in state 4.
- beq (000100):
  - With Zero=1: PCEn=1 in state 8, ALUOp=01, PCSource=01.
  - With Zero=0: PCEn=0 in state 8.
  - Returns to state 0 next cycle in both cases.
- ori (001101) then sw (101011):
  - ori: ALUOp=11 in state 12, then state 11 with RegWrite, RegDst=0.
  - sw: MemWrite+IorD in state 5, no RegWrite.
- Opcode 111111 in DECODE:
  - With ILLEGAL_OP_TRAP_EN: State=13, IllegalOp=1 until Reset.
  - Without it: next state 0, no enables asserted in the DECODE cycle.
- Reset=1 asserted while in MEMWR with MemReady=0: next state 0. MemWrite=0 in the reset cycle.
